// File: rtl/demux_1_8_deser.sv
// Serial-to-parallel deserializer: one bit per handshake is steered into lane cnt;
// a completed word is held in d (lane 0 = first bit) until the consumer takes it.
module demux_1_8_deser #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [0:WIDTH-1]         d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] sel
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t         state;
  logic           started;
  logic [CW-1:0]  cnt;
  logic [0:WIDTH-1] fill;
  logic [0:WIDTH-1] word_next;
  logic           last_lane;
  logic           in_fire;
  logic           out_fire;
  logic           complete;

  // Counter wraps at WIDTH-1 so non-power-of-two widths never index past the last lane.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == LAST) ? '0 : c + 1'b1;
  endfunction

  assign last_lane = (cnt == LAST);
  assign out_valid = (state == HOLD);
  // Only the completing bit has to wait for the holding register to drain.
  assign in_ready  = started & (~out_valid | out_ready | ~last_lane);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;
  assign complete  = in_fire & last_lane;
  assign sel       = cnt;

  always_comb begin
    word_next      = fill;
    word_next[cnt] = in_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      started <= 1'b0;
      cnt     <= '0;
      fill    <= '0;
      d       <= '0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        cnt  <= '0;
        fill <= '0;
      end else if (in_fire) begin
        cnt  <= cnt_inc(cnt);
        fill <= complete ? '0 : word_next;
      end
      // A word completing in the same cycle as out_fire replaces d with no bubble.
      if (complete) begin
        d     <= word_next;
        state <= HOLD;
      end else if (out_fire) begin
        state <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Bench for demux_1_8_deser: directed steps plus random traffic checked every cycle
// against a queue-based model of the word being assembled and the word on hold.
module tb_demux_1_8_deser;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [0:WIDTH-1] d;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       sel;

  int tests = 0;
  int fails = 0;

  // Reference model: bits of the word in progress, the held word, and its valid flag.
  bit               partial[$];
  logic [WIDTH-1:0] held;
  bit               has_word;
  bit               alive;
  int               stalls;

  always #5 clk = ~clk;

  demux_1_8_deser #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] word_of_partial();
    logic [WIDTH-1:0] w = '0;
    foreach (partial[i]) w = {w[WIDTH-2:0], partial[i]};
    return w;
  endfunction

  // One clock: drive at negedge, compare all outputs, then advance the model.
  task automatic cycle(input logic v, input logic b, input logic ordy, input logic fl,
                       output bit fired);
    bit exp_rdy, ofire, done;
    @(negedge clk);
    in_valid = v; in_bit = b; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = alive && (!has_word || ordy || partial.size() != WIDTH - 1);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(has_word));
    chk("d", 32'(d), 32'(held));
    chk("sel", 32'(sel), 32'(partial.size()));
    if (v && !in_ready) stalls++;
    fired = v && exp_rdy && !fl;
    ofire = has_word && ordy;
    done  = 1'b0;
    if (fl) partial.delete();
    else if (fired) begin
      partial.push_back(b);
      if (partial.size() == WIDTH) begin
        held = word_of_partial();
        partial.delete();
        done = 1'b1;
      end
    end
    if (done) has_word = 1'b1;
    else if (ofire) has_word = 1'b0;
    @(posedge clk);
    alive = 1'b1;
  endtask

  // Send bits [first .. first+n-1] of w (MSB = lane 0), holding each until accepted.
  task automatic send_bits(input logic [WIDTH-1:0] w, input int first, input int n,
                           input logic ordy);
    bit f;
    for (int i = first; i < first + n; i++) begin
      int tries = 0;
      do begin
        cycle(1'b1, w[WIDTH-1-i], ordy, 1'b0, f);
        tries++;
      end while (!f && tries < 40);
      if (!f) begin
        chk("send_timeout", 32'(f), 32'd1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    partial.delete(); held = '0; has_word = 1'b0; alive = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    alive = 1'b1;
  endtask

  initial begin
    bit f;
    logic [WIDTH-1:0] pend;
    int pos;
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    held = '0; has_word = 1'b0; alive = 1'b0; stalls = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single word 1,0,1,1,0,0,1,0
    send_bits(8'b10110010, 0, 8, 1'b1);
    #2;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_d", 32'(d), 32'hB2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, f);
    #2;
    chk("t2_drop", 32'(out_valid), 32'd0);

    // Back-pressure: first word held, second word fills to lane 6 then stalls
    send_bits(8'h3C, 0, 8, 1'b0);
    send_bits(8'h96, 0, 7, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, f);
    #2;
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_sel", 32'(sel), 32'd7);
    chk("t3_hold_d", 32'(d), 32'h3C);
    send_bits(8'h96, 7, 1, 1'b1);
    #2;
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_d2", 32'(d), 32'h96);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, f);

    // Back-to-back words with the consumer always ready
    stalls = 0;
    send_bits(8'h12, 0, 8, 1'b1);
    send_bits(8'hEF, 0, 8, 1'b1);
    #2;
    chk("t4_mid_d", 32'(d), 32'hEF);
    send_bits(8'h7B, 0, 8, 1'b1);
    #2;
    chk("t4_last_d", 32'(d), 32'h7B);
    chk("t4_stalls", 32'(stalls), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, f);

    // Flush a partial word (with in_valid high), then send 0xA5
    send_bits(8'hFF, 0, 5, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, f);
    #2;
    chk("t5_sel", 32'(sel), 32'd0);
    send_bits(8'hA5, 0, 8, 1'b1);
    #2;
    chk("t5_d", 32'(d), 32'hA5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, f);

    // Reset with a word on hold and four lanes filled
    send_bits(8'hC3, 0, 8, 1'b0);
    send_bits(8'hFF, 0, 4, 1'b0);
    #2;
    chk("t6_sel", 32'(sel), 32'd4);
    chk("t6_valid", 32'(out_valid), 32'd1);
    do_reset();
    send_bits(8'h5A, 0, 8, 1'b1);
    #2;
    chk("t6_d", 32'(d), 32'h5A);

    // Random traffic; the source holds a bit until it is taken
    pend = WIDTH'($urandom);
    pos = 0;
    for (int c = 0; c < 1500; c++) begin
      logic v, o, fl;
      v  = ($urandom_range(0, 3) != 0);
      o  = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 40) == 0);
      cycle(v, pend[WIDTH-1-pos], o, fl, f);
      if (f) begin
        pos++;
        if (pos == WIDTH) begin
          pos = 0;
          pend = WIDTH'($urandom);
        end
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, f);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
